seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 89 ++++++++
 tb/tb_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner: one digit per CLK_DIV-clock slot,
// blanking at slot start, frame-wide snapshot of N/status so a frame never tears.
module seg_scan_driver #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500,
    parameter int LZ_BLANK  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] N,
    input  logic [1:0]  status,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW:0]   BLANK_END = (CW + 1)'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_n_q, shadow_n_d;
    logic [1:0]    shadow_st_q, shadow_st_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic        tick, snap, dp_on, lz_off;
    logic [31:0] nib_shift;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
            4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
            4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
            4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
        endcase
        return r;
    endfunction

    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        snap         = tick && (idx_q == 3'd7);
        shadow_n_d   = snap ? N : shadow_n_q;
        shadow_st_d  = snap ? status : shadow_st_q;
        frame_done_d = snap;

        // Everything at and above the current nibble; zero means a leading zero.
        nib_shift = shadow_n_q >> {idx_q, 2'b00};
        dp_on     = (shadow_st_q != 2'd3) && (idx_q == (3'd4 + {1'b0, shadow_st_q}));
        lz_off    = (LZ_BLANK != 0) && (idx_q != 3'd0) && (nib_shift == 32'd0) && !dp_on;

        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (({1'b0, cnt_q} >= BLANK_END) && !lz_off) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = {~dp_on, hex7(nib_shift[3:0])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_n_q   <= 32'd0;
            shadow_st_q  <= 2'd0;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_n_q   <= shadow_n_d;
            shadow_st_q  <= shadow_st_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (plain and leading-zero blanking) checked each
// cycle against a time-based model, plus pinned literal expectations.
module tb_seg_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] N = 32'd0;
    logic [1:0]  status = 2'd0;
    logic [7:0]  an0, seg0, an1, seg1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK), .LZ_BLANK(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .N(N), .status(status),
        .an(an0), .seg(seg0), .frame_done(fd0));

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .N(N), .status(status),
        .an(an1), .seg(seg1), .frame_done(fd1));

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected {an, seg} for a given slot position and snapshot, straight from the display rules.
    function automatic logic [15:0] expect_out(input logic [31:0] n, input logic [1:0] st,
                                               input int c, input int i, input bit lz);
        bit         dp;
        logic [31:0] hi;
        logic [7:0]  a;
        if (c < BLANK) return 16'hFFFF;
        dp = (st != 2'd3) && (i == 4 + int'(st));
        hi = n >> (4 * i);
        if (lz && i > 0 && hi == 32'd0 && !dp) return 16'hFFFF;
        a = 8'hFF ^ (8'd1 << i);
        return {a, ~dp, hex_tab[hi[3:0]]};
    endfunction

    // Model: edges since reset give slot position directly; snapshot every 32nd edge.
    int unsigned e_q;
    logic [31:0] mn;
    logic [1:0]  mst;
    logic [15:0] exp0, exp1;
    logic        exp_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= 0;
            mn     <= 32'd0;
            mst    <= 2'd0;
            exp0   <= 16'hFFFF;
            exp1   <= 16'hFFFF;
            exp_fd <= 1'b0;
        end else begin
            exp0   <= expect_out(mn, mst, int'(e_q % 4), int'((e_q / 4) % 8), 1'b0);
            exp1   <= expect_out(mn, mst, int'(e_q % 4), int'((e_q / 4) % 8), 1'b1);
            exp_fd <= (e_q % 32 == 31);
            if (e_q % 32 == 31) begin
                mn  <= N;
                mst <= status;
            end
            e_q <= e_q + 1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("an", {24'd0, an0}, {24'd0, exp0[15:8]});
            chk("seg", {24'd0, seg0}, {24'd0, exp0[7:0]});
            chk("frame_done", {31'd0, fd0}, {31'd0, exp_fd});
            chk("an_lz", {24'd0, an1}, {24'd0, exp1[15:8]});
            chk("seg_lz", {24'd0, seg1}, {24'd0, exp1[7:0]});
            chk("frame_done_lz", {31'd0, fd1}, {31'd0, exp_fd});
            chk("an_onehot", {31'd0, ($countones(~an0) <= 1)}, 32'd1);
        end
    end

    // Returns at the negedge following the edge whose pre-edge slot position is (i, c).
    task automatic at_state(input int i, input int c);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (int'((e_q - 1) % 4) == c && int'(((e_q - 1) / 4) % 8) == i) break;
            if (n >= 80) begin
                chk("at_state_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk);
    endtask

    // Returns just after the edge that takes a snapshot.
    task automatic wait_snap();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (e_q % 32 == 0) break;
            if (n >= 40) begin
                chk("wait_snap_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        N      = 32'h12345678;
        status = 2'd0;
        #3 rst_n = 1'b0;
        #1 run = 1;
        #16;
        chk("rst_an", {24'd0, an0}, 32'h0000_00FF);
        chk("rst_seg", {24'd0, seg0}, 32'h0000_00FF);
        chk("rst_fd", {31'd0, fd0}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // First snapshot lands on edge 32.
        repeat (31) @(posedge clk);
        @(negedge clk);
        chk("fd_edge31", {31'd0, fd0}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fd_edge32", {31'd0, fd0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("fd_edge33", {31'd0, fd0}, 32'd0);
        chk("slot_start_blank", {24'd0, an0}, 32'h0000_00FF);

        at_state(0, 1);
        chk("d0_an", {24'd0, an0}, 32'h0000_00FE);
        chk("d0_seg", {24'd0, seg0}, 32'h0000_0080);
        at_state(4, 1);
        chk("d4_an", {24'd0, an0}, 32'h0000_00EF);
        chk("d4_seg_dp", {24'd0, seg0}, 32'h0000_0019);

        // Mid-frame change must not show until after the next snapshot.
        N = 32'h0000_000F;
        at_state(5, 1);
        chk("d5_old", {24'd0, seg0}, 32'h0000_00B0);
        wait_snap();
        at_state(0, 1);
        chk("d0_new", {24'd0, seg0}, 32'h0000_008E);

        // Decimal point placement by page.
        N = 32'd0;
        status = 2'd3;
        wait_snap();
        at_state(6, 2);
        chk("st3_d6", {24'd0, seg0}, 32'h0000_00C0);
        at_state(4, 2);
        chk("st3_d4", {24'd0, seg0}, 32'h0000_00C0);
        status = 2'd2;
        wait_snap();
        at_state(6, 2);
        chk("st2_d6_dp", {24'd0, seg0}, 32'h0000_0040);
        at_state(4, 2);
        chk("st2_d4", {24'd0, seg0}, 32'h0000_00C0);

        // Leading-zero blanking.
        N = 32'h0000_00A0;
        status = 2'd3;
        wait_snap();
        at_state(0, 1);
        chk("lz_d0_seg", {24'd0, seg1}, 32'h0000_00C0);
        chk("lz_d0_an", {24'd0, an1}, 32'h0000_00FE);
        at_state(1, 1);
        chk("lz_d1_seg", {24'd0, seg1}, 32'h0000_0088);
        at_state(2, 1);
        chk("lz_d2_an", {24'd0, an1}, 32'h0000_00FF);
        chk("nolz_d2_seg", {24'd0, seg0}, 32'h0000_00C0);
        at_state(7, 1);
        chk("lz_d7_seg", {24'd0, seg1}, 32'h0000_00FF);

        // Random traffic, checked by the model every cycle.
        for (int k = 0; k < 24; k++) begin
            N      = $urandom;
            if ($urandom_range(0, 2) == 0) N = N >> (4 * $urandom_range(1, 7));
            status = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 40)) @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset between edges.
        N = 32'h0000_0000;
        status = 2'd0;
        wait_snap();
        at_state(3, 2);
        N = 32'h8765_4321;
        @(posedge clk);
        #2;
        chk("pre_rst_an", {24'd0, an0}, 32'h0000_00F7);
        rst_n = 1'b0;
        #1;
        chk("async_an", {24'd0, an0}, 32'h0000_00FF);
        chk("async_seg", {24'd0, seg0}, 32'h0000_00FF);
        chk("async_fd", {31'd0, fd0}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        at_state(0, 1);
        chk("post_rst_d0", {24'd0, seg0}, 32'h0000_00C0);
        chk("post_rst_an", {24'd0, an0}, 32'h0000_00FE);
        wait_snap();
        at_state(0, 1);
        chk("post_rst_snap_d0", {24'd0, seg0}, 32'h0000_00F9);

        repeat (4) @(negedge clk);
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
